// File: rtl/led_status_arbiter_pkg.sv
// Shared LED/status definitions: FSM state encoding used by the
// arbiter and by the debug readout that decodes it.
package led_status_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PULSE_ON  = 2'd1,
        PULSE_OFF = 2'd2,
        GAP       = 2'd3
    } state_e;

    localparam int unsigned REQ_W = 4;

endpackage

// File: rtl/led_status_arbiter_tick_gen.sv
// Free-running slow-timer strobe: one-cycle tick every TICK_CNT_VAL
// sys_clk cycles, shared by the LED arbiter and other slow timers.
module tick_gen #(
    parameter logic [31:0] TICK_CNT_VAL = 32'd5000000
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    output logic tick
);

    logic [31:0] tick_cnt_q;
    logic [31:0] tick_cnt_d;

    always_comb begin
        tick       = (tick_cnt_q == TICK_CNT_VAL - 32'd1);
        tick_cnt_d = tick ? 32'd0 : tick_cnt_q + 32'd1;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tick_cnt_q <= 32'd0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
        end
    end

endmodule

// File: rtl/led_status_arbiter.sv
// Status LED arbiter: fixed-priority blink codes (i+1 pulses for
// requester i) with a heartbeat when nothing is requesting.
module led_status_arbiter
    import led_status_arbiter_pkg::*;
#(
    parameter logic [31:0] TICK_CNT_VAL = 32'd5000000,
    parameter logic [7:0]  GAP_TICKS    = 8'd10,
    parameter logic [7:0]  HB_TICKS     = 8'd5
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic [REQ_W-1:0] req,
    output logic             led_pin,
    output logic             busy,
    output logic [1:0]       grant_id
);

    logic       tick;
    logic [1:0] win_id;

    state_e     state_q, state_d;
    logic       led_q, led_d;
    logic [1:0] grant_q, grant_d;
    logic [1:0] pulse_q, pulse_d;
    logic [7:0] gap_q, gap_d;
    logic [7:0] hb_q, hb_d;

    tick_gen #(
        .TICK_CNT_VAL(TICK_CNT_VAL)
    ) u_tick_gen (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .tick     (tick)
    );

    // Lowest index wins: faults sit on the low bits.
    always_comb begin
        win_id = 2'd0;
        priority case (1'b1)
            req[0]:  win_id = 2'd0;
            req[1]:  win_id = 2'd1;
            req[2]:  win_id = 2'd2;
            req[3]:  win_id = 2'd3;
            default: win_id = 2'd0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        led_d   = led_q;
        grant_d = grant_q;
        pulse_d = pulse_q;
        gap_d   = gap_q;
        hb_d    = hb_q;
        if (tick) begin
            unique case (state_q)
                IDLE: begin
                    if (|req) begin
                        grant_d = win_id;
                        led_d   = 1'b1;
                        pulse_d = 2'd0;
                        state_d = PULSE_ON;
                    end else if (hb_q == HB_TICKS - 8'd1) begin
                        led_d = ~led_q;
                        hb_d  = 8'd0;
                    end else begin
                        hb_d = hb_q + 8'd1;
                    end
                end
                PULSE_ON: begin
                    led_d   = 1'b0;
                    state_d = PULSE_OFF;
                end
                PULSE_OFF: begin
                    if (pulse_q == grant_q) begin
                        gap_d   = 8'd0;
                        state_d = GAP;
                    end else begin
                        pulse_d = pulse_q + 2'd1;
                        led_d   = 1'b1;
                        state_d = PULSE_ON;
                    end
                end
                GAP: begin
                    if (gap_q != GAP_TICKS - 8'd1) begin
                        gap_d = gap_q + 8'd1;
                    end else if (|req) begin
                        grant_d = win_id;
                        led_d   = 1'b1;
                        pulse_d = 2'd0;
                        state_d = PULSE_ON;
                    end else begin
                        led_d   = 1'b0;
                        hb_d    = 8'd0;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
            led_q   <= 1'b0;
            grant_q <= 2'd0;
            pulse_q <= 2'd0;
            gap_q   <= 8'd0;
            hb_q    <= 8'd0;
        end else begin
            state_q <= state_d;
            led_q   <= led_d;
            grant_q <= grant_d;
            pulse_q <= pulse_d;
            gap_q   <= gap_d;
            hb_q    <= hb_d;
        end
    end

    assign led_pin  = led_q;
    assign busy     = (state_q != IDLE);
    assign grant_id = grant_q;

endmodule

// File: doc/led_status_arbiter.md
# led_status_arbiter

Shares the board's single status LED between up to four status sources and drives it with blink codes. Requester *i* is shown as *i+1* short pulses followed by a dark gap. With no requests pending, the LED shows a heartbeat. The block sits beside the top-level clock/reset logic and replaces the free-running LED toggler on boards where the LED must also report fault and busy conditions.

## Interface
- `TICK_CNT_VAL`, default 32'd5000000: sys_clk cycles per tick (100 ms at 50 MHz); must be ≥2.
- `GAP_TICKS`, default 8'd10: dark ticks after the last pulse of a code; must be ≥1.
- `HB_TICKS`, default 8'd5: ticks per heartbeat half-period in idle; must be ≥1.
- `sys_clk`  in  1  single clock; all logic on rising edge.
- `sys_rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  4  level requests; bit 0 has the highest priority; sampled only at ticks.
- `led_pin`  out  1  LED drive, 1 = lit.
- `busy`  out  1  1 while a blink code frame is in progress (state ≠ IDLE).
- `grant_id`  out  2  index of the requester currently being shown; holds its value in IDLE.

## Operation
- **Tick generator:** 32-bit `tick_cnt` counts 0..TICK_CNT_VAL-1 and wraps. `tick` is a one-cycle strobe asserted when `tick_cnt == TICK_CNT_VAL-1`. All FSM and LED updates happen only on `tick` cycles.
- **Arbitration:** fixed priority, lowest set bit of `req` wins. Arbitration happens only at a frame boundary, meaning an IDLE tick or the final GAP tick. A frame in progress is never pre-empted.
- **FSM states:** IDLE, PULSE_ON, PULSE_OFF, GAP. Counters: `pulse_cnt[1:0]`, `gap_cnt[7:0]`, `hb_cnt[7:0]`.
- **IDLE:**
  - On a tick with `req != 0`: latch `grant_id`, set `led_pin` to 1, clear `pulse_cnt`, go to PULSE_ON.
  - On a tick with `req == 0`: at `hb_cnt == HB_TICKS-1`, toggle `led_pin` and clear `hb_cnt`; otherwise increment `hb_cnt`.
- **PULSE_ON, on tick:** set `led_pin` to 0, go to PULSE_OFF.
- **PULSE_OFF, on tick:**
  - If `pulse_cnt == grant_id`: clear `gap_cnt`, go to GAP.
  - Else: increment `pulse_cnt`, set `led_pin` to 1, go to PULSE_ON.
- **GAP, on tick:**
  - If `gap_cnt == GAP_TICKS-1` and `req != 0`: re-arbitrate, latch `grant_id`, set `led_pin` to 1, clear `pulse_cnt`, go to PULSE_ON.
  - If `gap_cnt == GAP_TICKS-1` and `req == 0`: set `led_pin` to 0, clear `hb_cnt`, go to IDLE.
  - Otherwise: increment `gap_cnt`.
- **Request dropped mid-frame:** the frame still completes. A request pulse shorter than one tick that falls between ticks is not seen (by design, no latching).
- **Simultaneous requests:** the lowest index is served. Higher indices can starve while a lower one stays asserted; this is intended, since faults outrank busy indications.

## Timing
- **Reset values:**
  - `led_pin` = 0, `busy` = 0, `grant_id` = 0.
  - State = IDLE; `tick_cnt`, `hb_cnt`, `gap_cnt`, `pulse_cnt` = 0.
- **Reset mid-frame:** all outputs return to reset values immediately (asynchronous). The first tick occurs TICK_CNT_VAL cycles after the deassertion edge.
- **Output register timing:** all outputs are registered. `led_pin`, `busy` and `grant_id` change on the clock edge that ends the tick cycle.
- **Frame length** for grant *g*: 2(g+1)+GAP_TICKS ticks, measured from the first LED rising edge to the next arbitration point.
- **Response latency:** from `req` assertion in IDLE to LED on is at most TICK_CNT_VAL cycles.
- **Heartbeat period:** 2·HB_TICKS ticks.

## Structure
- **Shared package:** FSM state encoding (2-bit localparams IDLE=0, PULSE_ON=1, PULSE_OFF=2, GAP=3) goes in the shared LED/status package so that the debug readout can decode it.
- **Sub-module:** one natural sub-module, `tick_gen`, with parameter `TICK_CNT_VAL` and ports `sys_clk`, `sys_rst_n`, `tick`. It is reused by other slow timers.
- **Main module:** the priority encoder and FSM stay in the main module.

## Test plan
All scenarios use TICK_CNT_VAL=4, GAP_TICKS=3, HB_TICKS=2.
- **Reset, no requests:** `led_pin` = 0 during reset; after release it toggles every 8 cycles (period 16); `busy` = 0.
- **Single requester:** `req`=4'b0100 held -> 3 high pulses of 4 cycles each separated by 4-cycle lows, then 12 low cycles, repeating. `grant_id` = 2, `busy` = 1.
- **Priority and no pre-emption:** `req`=4'b1000, then `req[0]` is raised during the second pulse -> all 4 pulses of `grant_id` 3 complete, then the next frame shows 1 pulse with `grant_id` = 0.
- **Request withdrawn:** `req`=4'b0010 asserted, then dropped after the first pulse -> the 2-pulse frame and gap complete, then IDLE is entered (`busy` = 0) and the heartbeat resumes with `led_pin` = 0.
- **Asynchronous reset mid-frame:** `sys_rst_n` pulsed low during GAP -> `led_pin`, `busy` and `grant_id` go to 0 with no clock edge; operation restarts cleanly.
- **Sub-tick glitch:** a 1-cycle `req` pulse placed between ticks -> ignored, block stays in IDLE.
